// File: rtl/softmax_norm.sv
// softmax_norm: collects one row of N_ELEM e^x values (UQ3.6), sums them,
// then divides each element by the row sum with a bit-serial restoring
// divider and emits UQ0.8 probabilities in arrival order.
// Optional macro SOFTMAX_ROUND_EN: round-half-up quotient instead of floor.
module softmax_norm #(
  parameter int N_ELEM = 4,
  parameter int IN_W   = 9,
  parameter int OUT_W  = 8,
  parameter int SUM_W  = IN_W + $clog2(N_ELEM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  ex_in,
  input  logic             ex_vld_in,
  output logic             ex_rdy_out,
  output logic [OUT_W-1:0] prob_out,
  output logic             prob_vld_out,
  input  logic             prob_rdy_in,
  output logic             busy
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam int BIT_W = $clog2(OUT_W + 1);
  // One spare bit so the rounding term can never wrap the numerator.
  localparam int NUM_W = IN_W + OUT_W + 1;
  // Divisor is aligned to the quotient MSB (sum << OUT_W) on the first step.
  localparam int DVS_W = SUM_W + OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(OUT_W);

  typedef enum logic [1:0] {COLLECT, DIVIDE, OUTPUT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [IN_W-1:0]    buf_q [N_ELEM];
  logic [IN_W-1:0]    buf_d [N_ELEM];
  logic [NUM_W-1:0]   rem_q, rem_d;
  logic [OUT_W:0]     quo_q, quo_d;
  logic [OUT_W-1:0]   prob_q, prob_d;
  logic               vld_q, vld_d;
  logic               rdy_q, rdy_d;

  logic [NUM_W-1:0]   num;
  logic [NUM_W-1:0]   rem_cur;
  logic [NUM_W-1:0]   rem_nxt;
  logic [DVS_W-1:0]   dvs;
  logic [OUT_W:0]     quo_base;
  logic [OUT_W:0]     quo_nxt;
  logic [OUT_W-1:0]   sat;
  logic               qbit;

  assign ex_rdy_out   = rdy_q;
  assign prob_out     = prob_q;
  assign prob_vld_out = vld_q;
  assign busy         = (state_q != COLLECT);

  // Divider datapath: one restoring step per DIVIDE cycle, numerator
  // taken fresh from the buffer on the first step of each element.
  always_comb begin
    num = {1'b0, buf_q[idx_q], {OUT_W{1'b0}}};
`ifdef SOFTMAX_ROUND_EN
    num = num + NUM_W'(sum_q >> 1);
`endif
    rem_cur  = (bit_q == '0) ? num : rem_q;
    dvs      = {sum_q, {OUT_W{1'b0}}} >> bit_q;
    // A zero sum forces every quotient bit to 0 without changing timing.
    qbit     = (sum_q != '0) && (DVS_W'(rem_cur) >= dvs);
    rem_nxt  = qbit ? (rem_cur - NUM_W'(dvs)) : rem_cur;
    quo_base = (bit_q == '0) ? '0 : quo_q;
    quo_nxt  = {quo_base[OUT_W-1:0], qbit};
    // Quotient of exactly 2^OUT_W (element == sum) clamps to all ones.
    sat      = quo_q[OUT_W] ? '1 : quo_q[OUT_W-1:0];
  end

  // Control FSM: collect row, then divide/output each element in turn.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    sum_d   = sum_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    prob_d  = prob_q;
    vld_d   = vld_q;
    case (state_q)
      COLLECT: begin
        if (ex_vld_in && rdy_q) begin
          buf_d[cnt_q] = ex_in;
          sum_d        = sum_q + SUM_W'(ex_in);
          cnt_d        = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            idx_d   = '0;
            bit_d   = '0;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        if (bit_q == LAST_BIT) begin
          bit_d   = '0;
          state_d = OUTPUT;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      OUTPUT: begin
        // Registered output stage: load once, then hold until accepted.
        if (!vld_q) begin
          prob_d = sat;
          vld_d  = 1'b1;
        end else if (prob_rdy_in) begin
          vld_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            sum_d   = '0;
            state_d = COLLECT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DIVIDE;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
    rdy_d = (state_d == COLLECT);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      idx_q   <= '0;
      bit_q   <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      prob_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      for (int i = 0; i < N_ELEM; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      prob_q  <= prob_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      for (int i = 0; i < N_ELEM; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_softmax_norm.sv
// Scoreboard bench for softmax_norm: rows are pushed with their expected
// probabilities, a negedge monitor pops and compares on every transfer and
// also checks latency, stall stability and ex_rdy_out while busy.
module tb_softmax_norm;

  localparam int N   = 4;
  localparam int LAT = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] ex_in;
  logic       ex_vld_in;
  logic       ex_rdy_out;
  logic [7:0] prob_out;
  logic       prob_vld_out;
  logic       prob_rdy_in;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int cyc = 0;
  int in_cnt = 0;
  int out_in_row = 0;
  bit lat_pend = 0;
  int lat_exp = 0;
  bit stall_seen = 0;
  int stall_val = 0;
  int rdy_mode = 0;

  softmax_norm dut (
    .clk          (clk),
    .rst          (rst),
    .ex_in        (ex_in),
    .ex_vld_in    (ex_vld_in),
    .ex_rdy_out   (ex_rdy_out),
    .prob_out     (prob_out),
    .prob_vld_out (prob_vld_out),
    .prob_rdy_in  (prob_rdy_in),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: p = v / sum as UQ0.8, floor or round-half-up, clamped.
  function automatic int ref_prob(input int v, input int s);
    int q;
    if (s == 0) return 0;
`ifdef SOFTMAX_ROUND_EN
    q = (v * 256 + s / 2) / s;
`else
    q = (v * 256) / s;
`endif
    return (q > 255) ? 255 : q;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: samples on the falling edge; a vld&rdy seen here transfers
  // on the next rising edge (edge number cyc+1).
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) chk("ex_rdy_low_while_busy", int'(ex_rdy_out), 0);
      if (ex_vld_in && ex_rdy_out) begin
        in_cnt++;
        if (in_cnt % N == 0) begin
          lat_pend = 1;
          lat_exp  = cyc + 1 + LAT;
        end
      end
      if (prob_vld_out) begin
        if (lat_pend) begin
          chk("latency", cyc, lat_exp);
          lat_pend = 0;
        end
        if (stall_seen) chk("stall_hold_prob", int'(prob_out), stall_val);
        if (prob_rdy_in) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", int'(prob_out), -1);
          end else begin
            chk("prob", int'(prob_out), exp_q.pop_front());
          end
          out_in_row++;
          if (out_in_row == N) begin
            out_in_row = 0;
          end else begin
            lat_pend = 1;
            lat_exp  = cyc + 1 + LAT;
          end
          stall_seen = 0;
        end else begin
          stall_seen = 1;
          stall_val  = int'(prob_out);
        end
      end else if (stall_seen) begin
        chk("stall_vld_held", 0, 1);
        stall_seen = 0;
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = 5-cycle stall per output.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: prob_rdy_in = 1'b1;
        1: prob_rdy_in = 1'($urandom_range(0, 1));
        default: begin
          if (!prob_vld_out) begin
            prob_rdy_in = 1'b0;
            stall_cnt   = 0;
          end else if (!prob_rdy_in) begin
            stall_cnt++;
            if (stall_cnt >= 6) prob_rdy_in = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic send_row(input int v0, input int v1, input int v2, input int v3);
    int v[4];
    int s;
    int t;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    s = v0 + v1 + v2 + v3;
    for (int i = 0; i < N; i++) exp_q.push_back(ref_prob(v[i], s));
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ex_vld_in = 1'b0;
        ex_in     = 9'($urandom);
        @(posedge clk);
        #1;
      end
      ex_in     = 9'(v[i]);
      ex_vld_in = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (ex_rdy_out) break;
        t++;
        if (t > 2000) begin
          chk("input_accept_timeout", 0, 1);
          break;
        end
      end
      @(posedge clk);
      #1;
      ex_vld_in = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) chk("row_done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    ex_in     = '0;
    ex_vld_in = 1'b0;
    prob_rdy_in = 1'b0;
    #12;
    chk("reset_prob_vld", int'(prob_vld_out), 0);
    chk("reset_prob_out", int'(prob_out), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_reset", int'(ex_rdy_out), 1);

    // Directed rows, downstream always ready.
    rdy_mode = 0;
    send_row(64, 64, 64, 64);   wait_done();
    send_row(64, 128, 32, 32);  wait_done();
    send_row(100, 0, 0, 0);     wait_done();
    send_row(0, 0, 0, 0);       wait_done();
    send_row(2, 1, 0, 0);       wait_done();
    send_row(511, 511, 511, 511); wait_done();

    // Backpressure with ex_vld_in toggling while the stage is busy.
    rdy_mode = 2;
    send_row(10, 20, 30, 40);
    t = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy || t > 3000) break;
      ex_vld_in = 1'($urandom_range(0, 1));
      ex_in     = 9'($urandom);
      t++;
    end
    ex_vld_in = 1'b0;
    wait_done();
    send_row(200, 7, 300, 1);   wait_done();

    // Random rows with random downstream ready.
    rdy_mode = 1;
    for (int r = 0; r < 12; r++) begin
      if (r % 5 == 4)
        send_row(0, int'($urandom_range(0, 511)), 0, 0);
      else
        send_row(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
    end
    wait_done();

    // Asynchronous reset in the middle of element 2's division.
    rdy_mode = 0;
    send_row(64, 128, 32, 32);
    t = 0;
    while (out_in_row != 2 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 2000) chk("reset_setup_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_prob_vld", int'(prob_vld_out), 0);
    chk("midreset_prob_out", int'(prob_out), 0);
    chk("midreset_busy", int'(busy), 0);
    exp_q.delete();
    in_cnt     = 0;
    out_in_row = 0;
    lat_pend   = 0;
    stall_seen = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdy_after_midreset", int'(ex_rdy_out), 1);
    send_row(64, 64, 64, 64);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
- Softmax normalisation stage directly downstream of the attention row MAC / e^x unit.
- Collects one row of N_ELEM unsigned e^x values (UQ3.6) over a valid/ready slave port and sums them.
- Divides each value by the row sum with a bit-serial restoring divider.
- Emits N_ELEM probabilities (UQ0.8) in arrival order over a valid/ready master port.

Parameters:
- N_ELEM, 4, elements per row; power of two, at least 2.
- IN_W, 9, e^x input width, UQ3.6.
- OUT_W, 8, probability output width, UQ0.8.
- SUM_W, IN_W+$clog2(N_ELEM) (= 11), row-sum accumulator width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_in  in  IN_W  e^x value, UQ3.6.
- ex_vld_in  in  1  ex_in valid.
- ex_rdy_out  out  1  stage can accept ex_in.
- prob_out  out  OUT_W  normalised probability, UQ0.8.
- prob_vld_out  out  1  prob_out valid.
- prob_rdy_in  in  1  downstream accepts prob_out.
- busy  out  1  high in any state other than COLLECT.

Behaviour:
- Reset (asynchronous, active-high, may occur at any cycle, including mid-division):
  - state=COLLECT, elem/idx counters=0, sum=0, buffer cleared.
  - prob_out=0, prob_vld_out=0, busy=0.
  - ex_rdy_out=1 on the first edge after rst deasserts.
  - Any partial row is discarded.
- Handshakes: a transfer occurs on a rising edge with vld&rdy both high.
  - prob_out is held stable while prob_vld_out=1 and prob_rdy_in=0.
  - prob_vld_out does not depend combinationally on prob_rdy_in.
- COLLECT:
  - ex_rdy_out=1.
  - Each transfer writes buf[cnt]<=ex_in, sum<=sum+ex_in (SUM_W, never overflows) and increments cnt.
  - On transfer number N_ELEM: cnt wraps to 0, idx<=0, go to DIVIDE.
- DIVIDE:
  - ex_rdy_out=0.
  - Numerator = buf[idx]<<OUT_W (IN_W+OUT_W bits); divisor = sum.
  - Restoring divide produces a quotient of OUT_W+1 bits at one bit per cycle, so DIVIDE lasts exactly OUT_W+1 cycles (9 by default).
  - Then go to OUTPUT with prob_out loaded.
- Result rules:
  - Quotient ≥ 2^OUT_W saturates to 2^OUT_W−1 (255). This occurs when the element equals the row sum.
  - sum==0 gives prob_out=0 for every element; the divider is bypassed but the cycle count is unchanged.
- OUTPUT:
  - prob_vld_out=1 until the transfer.
  - On transfer, if idx<N_ELEM−1: idx++, return to DIVIDE.
  - Otherwise: sum<=0, go to COLLECT. ex_rdy_out=1 on the following cycle.
- Latency:
  - Last input transfer to first prob_vld_out: OUT_W+2 cycles.
  - Output transfer to next prob_vld_out: OUT_W+2 cycles.
- Throughput: no input/output overlap. A new row is not accepted until all N_ELEM outputs of the current row have been transferred.

Optional Feature:
- Macro: SOFTMAX_ROUND_EN.
- Defined: numerator = (buf[idx]<<OUT_W) + (sum>>1), giving round-half-up. Saturation and cycle counts are unchanged.
- Undefined: truncating quotient (floor).

Test Plan:
- Equal row 64,64,64,64 (1.0 each), prob_rdy_in=1:
  - sum=256, outputs 64,64,64,64.
  - First prob_vld_out 10 cycles after the 4th input transfer.
  - ex_rdy_out low throughout DIVIDE/OUTPUT.
- Mixed row 64,128,32,32 → outputs 64,128,32,32, in input order.
- Saturation / zero cases:
  - 100,0,0,0 → 255,0,0,0.
  - 0,0,0,0 → 0,0,0,0 with unchanged timing.
- Rounding, row 2,1,0,0 (sum=3):
  - Without SOFTMAX_ROUND_EN → 170,85,0,0.
  - With SOFTMAX_ROUND_EN → 171,85,0,0.
- Backpressure:
  - Hold prob_rdy_in=0 for 5 cycles on each output → prob_out stable and prob_vld_out held high.
  - ex_vld_in toggling during this time is ignored (no transfer); the next row is processed correctly afterwards.
- Async reset mid-DIVIDE of element 2:
  - prob_vld_out=0, prob_out=0, busy=0 immediately.
  - After release, a fresh row 64,64,64,64 yields 64×4.
